// File: rtl/pu_or1k_pfpu32_f2i.sv
// pfpu32 lf.ftoi.s: two-stage binary32 -> int32 with rounding and saturation.
// Ports: clk/rst, flush_i/adv_i pipe control, start_i/rmode_i/opa_i request,
// f2i_rdy_o/f2i_result_o/f2i_inv_o/f2i_ine_o result and flags.
module pu_or1k_pfpu32_f2i (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        adv_i,
  input  logic        start_i,
  input  logic [1:0]  rmode_i,
  input  logic [31:0] opa_i,
  output logic        f2i_rdy_o,
  output logic [31:0] f2i_result_o,
  output logic        f2i_inv_o,
  output logic        f2i_ine_o
);

  // stage 1: decode
  logic        w_s;
  logic [7:0]  w_e;
  logic [23:0] w_m;
  logic        w_nan;
  logic        w_min;
  logic        w_inv;
  logic        w_shl;
  logic [7:0]  w_dl;
  logic [7:0]  w_dr;
  logic [4:0]  w_sh;

  assign w_s   = opa_i[31];
  assign w_e   = opa_i[30:23];
  assign w_m   = {|w_e, opa_i[22:0]};
  assign w_nan = (&w_e) & (|opa_i[22:0]);
  // -2^31 is the one representable value with e=158
  assign w_min = (opa_i == 32'hCF00_0000);
  // NaN and infinity are covered by e>=158 as well
  assign w_inv = (w_e >= 8'd158) & ~w_min;
  assign w_shl = (w_e >= 8'd150);
  assign w_dl  = w_e - 8'd150;
  assign w_dr  = 8'd150 - w_e;
  // right shifts beyond 26 leave only sticky information, so clamp
  assign w_sh  = w_shl ? w_dl[4:0] :
                 (w_dr > 8'd26) ? 5'd26 : w_dr[4:0];

  logic        r1_vld;
  logic        r1_s;
  logic        r1_inv;
  logic        r1_sat_s;
  logic        r1_shl;
  logic [4:0]  r1_sh;
  logic [23:0] r1_m;
  logic [1:0]  r1_rm;

  // stage 2: shift / round
  logic [49:0] w_ext;
  logic [23:0] w_q;
  logic        w_g;
  logic        w_t;
  logic        w_inc;
  logic [31:0] w_mag;
  logic [31:0] w_int;
  logic [31:0] w_res;
  logic        w_ine;

  // m sits above 26 zero bits so guard/sticky fall out of the shift
  assign w_ext = {r1_m, 26'd0} >> r1_sh;
  assign w_q   = w_ext[49:26];
  assign w_g   = w_ext[25];
  assign w_t   = |w_ext[24:0];

  always_comb begin
    w_inc = 1'b0;
    case (r1_rm)
      2'b00:   w_inc = w_g & (w_t | w_q[0]);
      2'b01:   w_inc = 1'b0;
      2'b10:   w_inc = ~r1_s & (w_g | w_t);
      default: w_inc = r1_s & (w_g | w_t);
    endcase
  end

  assign w_mag = r1_shl ? ({8'd0, r1_m} << r1_sh)
                        : ({8'd0, w_q} + {31'd0, w_inc});
  assign w_int = r1_s ? (32'd0 - w_mag) : w_mag;
  assign w_res = r1_inv ? (r1_sat_s ? 32'h8000_0000 : 32'h7FFF_FFFF)
                        : w_int;
  assign w_ine = ~r1_inv & ~r1_shl & (w_g | w_t);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_vld    <= 1'b0;
      f2i_rdy_o <= 1'b0;
    end else if (flush_i) begin
      r1_vld    <= 1'b0;
      f2i_rdy_o <= 1'b0;
    end else if (adv_i) begin
      r1_vld    <= start_i;
      f2i_rdy_o <= r1_vld;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_s         <= 1'b0;
      r1_inv       <= 1'b0;
      r1_sat_s     <= 1'b0;
      r1_shl       <= 1'b0;
      r1_sh        <= 5'd0;
      r1_m         <= 24'd0;
      r1_rm        <= 2'd0;
      f2i_result_o <= 32'd0;
      f2i_inv_o    <= 1'b0;
      f2i_ine_o    <= 1'b0;
    end else if (adv_i) begin
      r1_s         <= w_s;
      r1_inv       <= w_inv;
      r1_sat_s     <= w_s & ~w_nan;
      r1_shl       <= w_shl;
      r1_sh        <= w_sh;
      r1_m         <= w_m;
      r1_rm        <= rmode_i;
      f2i_result_o <= w_res;
      f2i_inv_o    <= r1_inv;
      f2i_ine_o    <= w_ine;
    end
  end

endmodule
